// File: rtl/uart_alu_interface.sv
// Assembles three UART bytes into ALU operand A, operand B and opcode, then hands the ALU result to Tx.
// Optional inter-byte timeout is compiled in with `define RX_TIMEOUT_EN.
//
// state   | meaning
// WAIT_A  | waiting for operand A byte
// WAIT_B  | waiting for operand B byte
// WAIT_OP | waiting for opcode byte
// COMPUTE | one cycle: latch ALU result, raise TX_START
// SEND    | waiting for Tx to finish (TX_DONE)
module uart_alu_interface #(
    parameter int N_BITS         = 8,
    parameter int OP_BITS        = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               RX_DONE,
    input  logic [N_BITS-1:0]  DIN,
    input  logic [N_BITS-1:0]  ALU_RESULT,
    input  logic               TX_DONE,
    output logic [N_BITS-1:0]  ALU_A,
    output logic [N_BITS-1:0]  ALU_B,
    output logic [OP_BITS-1:0] ALU_OP,
    output logic               TX_START,
    output logic [N_BITS-1:0]  TX_DATA,
    output logic [2:0]         STATE
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        COMPUTE = 3'd3,
        SEND    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [N_BITS-1:0]   a_q, a_d;
    logic [N_BITS-1:0]   b_q, b_d;
    logic [OP_BITS-1:0]  op_q, op_d;
    logic [N_BITS-1:0]   data_q, data_d;
    logic                start_q, start_d;
    logic                tmo_hit;
    logic                in_wait_bytes;

    assign in_wait_bytes = (state_q == WAIT_B) || (state_q == WAIT_OP);

`ifdef RX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;

    // Down-counter reloads on any byte and outside WAIT_B/WAIT_OP; zero is the terminal count.
    always_comb begin
        tmo_d = TMO_LOAD;
        if (in_wait_bytes && !RX_DONE && (tmo_q != '0)) begin
            tmo_d = tmo_q - TW'(1);
        end
    end

    assign tmo_hit = in_wait_bytes && (tmo_q == '0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_q <= TMO_LOAD;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        start_d = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (RX_DONE) begin
                    a_d     = DIN;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (RX_DONE) begin
                    b_d     = DIN;
                    state_d = WAIT_OP;
                end else if (tmo_hit) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (RX_DONE) begin
                    op_d    = DIN[OP_BITS-1:0];
                    state_d = COMPUTE;
                end else if (tmo_hit) begin
                    state_d = WAIT_A;
                end
            end
            COMPUTE: begin
                data_d  = ALU_RESULT;
                start_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                // A byte arriving alongside TX_DONE is dropped, not taken as A.
                if (TX_DONE) begin
                    state_d = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign ALU_A    = a_q;
    assign ALU_B    = b_q;
    assign ALU_OP   = op_q;
    assign TX_DATA  = data_q;
    assign TX_START = start_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface: directed scenarios plus randomized transactions
// checked against an arithmetic reference; timeout scenarios follow RX_TIMEOUT_EN.
module tb_uart_alu_interface;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RX_DONE = 1'b0;
    logic       TX_DONE = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [7:0] ALU_RESULT;
    logic [7:0] ALU_A, ALU_B, TX_DATA;
    logic [5:0] ALU_OP;
    logic       TX_START;
    logic [2:0] STATE;

    int checks = 0;
    int errors = 0;
    int tx_pulses = 0;

    always #5 CLK = ~CLK;

    uart_alu_interface #(
        .N_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK), .RESET(RESET), .RX_DONE(RX_DONE), .DIN(DIN),
        .ALU_RESULT(ALU_RESULT), .TX_DONE(TX_DONE),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
        .TX_START(TX_START), .TX_DATA(TX_DATA), .STATE(STATE)
    );

    // External combinational ALU (MIPS-style function codes).
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign ALU_RESULT = alu_fn(ALU_A, ALU_B, ALU_OP);

    // Reference result from the bytes sent, using integer arithmetic.
    function automatic int ref_result(input int a, input int b, input int op);
        int sa;
        sa = (a >= 128) ? a - 256 : a;
        case (op % 64)
            32:      return (a + b) % 256;
            34:      return (a - b + 256) % 256;
            36:      return a & b;
            37:      return a | b;
            38:      return a ^ b;
            39:      return 255 - (a | b);
            2:       return a / (1 << (b % 8));
            3:       return ((sa >>> (b % 8)) + 256) % 256;
            default: return 0;
        endcase
    endfunction

    always @(negedge CLK) if (TX_START === 1'b1) tx_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves RX_DONE high across exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        RX_DONE = 1'b1;
        DIN = b;
        @(negedge CLK);
        RX_DONE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // inject: 0 none, 1 stray byte during SEND, 2 stray byte together with TX_DONE
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                           input int gap, input int inject);
        int exp;
        exp = ref_result(int'(a), int'(b), int'(op_byte));
        send_byte(a);
        chk("state_after_a", 32'(STATE), 32'd1);
        chk("alu_a", 32'(ALU_A), 32'(a));
        idle(gap);
        send_byte(b);
        chk("state_after_b", 32'(STATE), 32'd2);
        chk("alu_b", 32'(ALU_B), 32'(b));
        idle(gap);
        send_byte(op_byte);
        chk("state_compute", 32'(STATE), 32'd3);
        chk("alu_op", 32'(ALU_OP), 32'(op_byte[5:0]));
        chk("tx_start_early", 32'(TX_START), 32'd0);
        @(negedge CLK);
        chk("tx_start_t2", 32'(TX_START), 32'd1);
        chk("state_send", 32'(STATE), 32'd4);
        chk("tx_data", 32'(TX_DATA), 32'(exp));
        @(negedge CLK);
        chk("tx_start_single", 32'(TX_START), 32'd0);
        if (inject == 1) begin
            send_byte(8'hAA);
            chk("rx_in_send_a", 32'(ALU_A), 32'(a));
            chk("rx_in_send_state", 32'(STATE), 32'd4);
        end
        idle(gap);
        TX_DONE = 1'b1;
        if (inject == 2) begin
            RX_DONE = 1'b1;
            DIN = 8'hAA;
        end
        @(negedge CLK);
        TX_DONE = 1'b0;
        RX_DONE = 1'b0;
        chk("state_after_txdone", 32'(STATE), 32'd0);
        chk("alu_a_hold", 32'(ALU_A), 32'(a));
        chk("tx_data_hold", 32'(TX_DATA), 32'(exp));
    endtask

    initial begin
        logic [5:0] ops [8];
        int p0;
        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};

        // Reset held two cycles
        idle(2);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        chk("rst_alu_b", 32'(ALU_B), 32'd0);
        chk("rst_alu_op", 32'(ALU_OP), 32'd0);
        chk("rst_tx_data", 32'(TX_DATA), 32'd0);
        chk("rst_tx_start", 32'(TX_START), 32'd0);
        chk("rst_state", 32'(STATE), 32'd0);
        RESET = 1'b0;
        idle(1);

        // Asynchronous reset while in WAIT_OP
        send_byte(8'h44);
        send_byte(8'h55);
        chk("pre_rst_state", 32'(STATE), 32'd2);
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_state", 32'(STATE), 32'd0);
        chk("async_rst_a", 32'(ALU_A), 32'd0);
        chk("async_rst_b", 32'(ALU_B), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        idle(1);

        // TX_DONE outside SEND is ignored
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        chk("txdone_wait_a", 32'(STATE), 32'd0);

        // Basic ADD, then stray byte during SEND, then a normal transaction
        p0 = tx_pulses;
        run_txn(8'h05, 8'h03, 8'h20, 0, 0);
        run_txn(8'h05, 8'h03, 8'h20, 1, 1);
        run_txn(8'h07, 8'h02, 8'h22, 0, 0);
        chk("pulses_three", 32'(tx_pulses - p0), 32'd3);

        // Back-to-back, and RX_DONE coincident with TX_DONE
        p0 = tx_pulses;
        run_txn(8'hFF, 8'h01, 8'h20, 0, 2);
        run_txn(8'h0F, 8'hF0, 8'h24, 0, 0);
        chk("pulses_two", 32'(tx_pulses - p0), 32'd2);

        // TX_DONE in WAIT_B is ignored
        send_byte(8'h21);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        chk("txdone_wait_b", 32'(STATE), 32'd1);
        send_byte(8'h12);
        send_byte(8'hE5);   // upper bits of opcode byte must be discarded
        chk("op_trunc", 32'(ALU_OP), 32'h25);
        idle(1);
        chk("or_result", 32'(TX_DATA), 32'h33);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        chk("or_done", 32'(STATE), 32'd0);

        // Randomized transactions
        for (int i = 0; i < 10; i++) begin
            logic [7:0] ra, rb, rop;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = {2'($urandom), ops[$urandom_range(0, 7)]};
            run_txn(ra, rb, rop, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
        end

`ifdef RX_TIMEOUT_EN
        // RX_DONE on the terminal-count cycle is captured
        send_byte(8'h31);
        idle(15);
        chk("tmo_edge_state", 32'(STATE), 32'd1);
        send_byte(8'h13);
        chk("tmo_edge_capture", 32'(STATE), 32'd2);
        chk("tmo_edge_b", 32'(ALU_B), 32'h13);
        idle(15);
        chk("tmo_op_edge", 32'(STATE), 32'd2);
        idle(1);
        chk("tmo_op_expired", 32'(STATE), 32'd0);

        // Idle after one byte times out; partial operand stays but next txn is clean
        send_byte(8'h11);
        idle(20);
        chk("tmo_state", 32'(STATE), 32'd0);
        chk("tmo_keep_a", 32'(ALU_A), 32'h11);
        run_txn(8'h22, 8'h33, 8'h20, 0, 0);
        chk("tmo_result", 32'(TX_DATA), 32'h55);
`else
        // Without the timeout the FSM waits indefinitely
        send_byte(8'h11);
        idle(2000);
        chk("no_tmo_state", 32'(STATE), 32'd1);
        send_byte(8'h22);
        send_byte(8'h20);
        idle(1);
        chk("no_tmo_result", 32'(TX_DATA), 32'h33);
        TX_DONE = 1'b1;
        @(negedge CLK);
        TX_DONE = 1'b0;
        chk("no_tmo_done", 32'(STATE), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
